// File: rtl/dmem_responder_if.sv
// Request/acknowledge bundle between the channel masters and dmem_responder.
// Every channel has one read port and one write port, each using a four-phase valid/ready handshake.
interface dmem_responder_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8
);
  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-channel data memory responder with a fixed request-to-ready latency.
// Each channel has an independent read FSM and an independent write FSM that share one storage array.

module dmem_chan_fsm #(
  parameter int PAYLOAD_BITS = 8,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [PAYLOAD_BITS-1:0] payload,
  output logic                    ready,
  output logic                    commit,
  output logic [PAYLOAD_BITS-1:0] commit_payload
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [PAYLOAD_BITS-1:0] pl_q, pl_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pl_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pl_q  <= pl_nxt;
    end
  end

  // commit marks the edge that enters DONE; that is where the array is sampled or updated
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pl_nxt    = pl_q;
    commit    = 1'b0;
    case (state)
      IDLE: if (valid) begin
        pl_nxt  = payload;
        cnt_nxt = CNT_INIT;
        if (LATENCY == 1) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end else begin
          state_nxt = BUSY;
        end
      end
      BUSY: if (!valid) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end
      end
      DONE: if (!valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == DONE);
  // With LATENCY=1 the commit happens on the accepting edge, before the latch holds the payload
  assign commit_payload = (state == IDLE) ? payload : pl_q;
endmodule

module dmem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_responder_if.slave      bus,
  input  logic                 load_enable,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int WPL   = ADDR_BITS + DATA_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [NUM_CHANNELS-1:0]                rd_ready, wr_ready, rd_commit, wr_commit;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_addr;
  logic [NUM_CHANNELS-1:0][WPL-1:0]       wr_pl;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    dmem_chan_fsm #(.PAYLOAD_BITS(ADDR_BITS), .LATENCY(LATENCY)) u_rd (
      .clk            (clk),
      .reset          (reset),
      .valid          (bus.mem_read_valid[c]),
      .payload        (bus.mem_read_address[c]),
      .ready          (rd_ready[c]),
      .commit         (rd_commit[c]),
      .commit_payload (rd_addr[c])
    );

    dmem_chan_fsm #(.PAYLOAD_BITS(WPL), .LATENCY(LATENCY)) u_wr (
      .clk            (clk),
      .reset          (reset),
      .valid          (bus.mem_write_valid[c]),
      .payload        ({bus.mem_write_address[c], bus.mem_write_data[c]}),
      .ready          (wr_ready[c]),
      .commit         (wr_commit[c]),
      .commit_payload (wr_pl[c])
    );
  end

  // Storage is never reset. Later assignments win, so the backdoor load yields to any channel write
  // and higher-numbered channels override lower ones.
  always_ff @(posedge clk) begin
    if (load_enable) mem[load_address] <= load_data;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (wr_commit[c]) mem[wr_pl[c][WPL-1:DATA_BITS]] <= wr_pl[c][DATA_BITS-1:0];
  end

  // Reads sample the array before this edge's writes land, so they return the pre-write value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (rd_commit[c]) rd_data_q[c] <= mem[rd_addr[c]];
    end
  end

  assign bus.mem_read_ready  = rd_ready;
  assign bus.mem_write_ready = wr_ready;
  assign bus.mem_read_data   = rd_data_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: a word-array model predicts read data, and a monitor
// checks every read acknowledge. A second instance with LATENCY=3 covers simultaneous multi-channel reads.
module tb_dmem_responder;
  localparam int NC = 4;
  localparam int AB = 8;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          load_enable, load_enable3;
  logic [AB-1:0] load_address, load_address3;
  logic [DB-1:0] load_data, load_data3;

  dmem_responder_if #(.NUM_CHANNELS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();
  dmem_responder_if #(.NUM_CHANNELS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) bus3 ();

  dmem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .load_enable(load_enable), .load_address(load_address), .load_data(load_data)
  );

  dmem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave),
    .load_enable(load_enable3), .load_address(load_address3), .load_data(load_data3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DB-1:0] model [1 << AB];

  typedef struct {
    int            ch;
    logic [DB-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0][7:0] pk(input logic [7:0] a0, a1, a2, a3);
    logic [NC-1:0][7:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  // Monitor: every rising read ready consumes the oldest expectation for that channel;
  // data must then stay unchanged for as long as ready stays high.
  logic [NC-1:0]         rr_prev = '0;
  logic [NC-1:0][DB-1:0] held;
  always @(posedge clk) begin
    int idx;
    #1;
    for (int c = 0; c < NC; c++) begin
      if (bus.mem_read_ready[c] && !rr_prev[c]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].ch == c) idx = i;
        if (idx < 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_ready: ch%0d data %0h with no pending request", c,
                   bus.mem_read_data[c]);
        end else begin
          check($sformatf("rd_data_ch%0d", c), bus.mem_read_data[c], sb[idx].data);
          sb.delete(idx);
          held[c] = bus.mem_read_data[c];
        end
      end else if (bus.mem_read_ready[c]) begin
        check($sformatf("rd_data_hold_ch%0d", c), bus.mem_read_data[c], held[c]);
      end
    end
    rr_prev = bus.mem_read_ready;
  end

  task automatic load(input logic [AB-1:0] a, input logic [DB-1:0] d);
    @(negedge clk);
    load_enable = 1'b1; load_address = a; load_data = d;
    model[a] = d;
    @(negedge clk);
    load_enable = 1'b0;
  endtask

  // One synchronized round on the LATENCY=2 instance: every active channel raises valid on the same
  // cycle, so all reads sample and all writes commit on the same edge. Aborted writes drop valid while
  // busy; an optional backdoor load lands on the commit edge.
  task automatic issue_round(input logic [NC-1:0] re, we, ab,
                             input logic [NC-1:0][AB-1:0] ra, wa,
                             input logic [NC-1:0][DB-1:0] wd,
                             input int hold,
                             input logic ld_en, input logic [AB-1:0] ld_a, input logic [DB-1:0] ld_d);
    logic [NC-1:0] wexp;
    wexp = we & ~ab;
    for (int c = 0; c < NC; c++)
      if (re[c]) sb.push_back('{c, model[ra[c]]});
    if (ld_en) model[ld_a] = ld_d;
    for (int c = 0; c < NC; c++)
      if (wexp[c]) model[wa[c]] = wd[c];

    @(negedge clk);
    bus.mem_read_valid    = re;
    bus.mem_read_address  = ra;
    bus.mem_write_valid   = we;
    bus.mem_write_address = wa;
    bus.mem_write_data    = wd;
    @(negedge clk);
    check("rd_ready_busy", bus.mem_read_ready, '0);
    check("wr_ready_busy", bus.mem_write_ready, '0);
    bus.mem_write_valid   = wexp;
    bus.mem_read_address  = $urandom;
    bus.mem_write_address = $urandom;
    bus.mem_write_data    = $urandom;
    load_enable = ld_en; load_address = ld_a; load_data = ld_d;
    @(negedge clk);
    load_enable = 1'b0;
    check("rd_ready_lat", bus.mem_read_ready, re);
    check("wr_ready_lat", bus.mem_write_ready, wexp);
    repeat (hold) begin
      @(negedge clk);
      check("rd_ready_hold", bus.mem_read_ready, re);
      check("wr_ready_hold", bus.mem_write_ready, wexp);
    end
    bus.mem_read_valid  = '0;
    bus.mem_write_valid = '0;
    @(negedge clk);
    check("ready_drop", {bus.mem_read_ready, bus.mem_write_ready}, '0);
  endtask

  task automatic rand_round();
    logic [NC-1:0] re, we, ab;
    logic [NC-1:0][AB-1:0] ra, wa;
    logic [NC-1:0][DB-1:0] wd;
    re = NC'($urandom);
    we = NC'($urandom);
    ab = we & NC'($urandom) & NC'($urandom);
    for (int c = 0; c < NC; c++) begin
      ra[c] = AB'($urandom_range(0, 15));
      wa[c] = AB'($urandom_range(0, 15));
      wd[c] = DB'($urandom);
    end
    issue_round(re, we, ab, ra, wa, wd, $urandom_range(0, 2),
                1'($urandom_range(0, 1)), AB'($urandom_range(0, 15)), DB'($urandom));
  endtask

  initial begin
    int k;
    reset = 1'b0;
    bus.mem_read_valid = '0;  bus.mem_read_address = '0;
    bus.mem_write_valid = '0; bus.mem_write_address = '0; bus.mem_write_data = '0;
    bus3.mem_read_valid = '0;  bus3.mem_read_address = '0;
    bus3.mem_write_valid = '0; bus3.mem_write_address = '0; bus3.mem_write_data = '0;
    load_enable = 1'b0;  load_address = '0;  load_data = '0;
    load_enable3 = 1'b0; load_address3 = '0; load_data3 = '0;

    #1;
    check("reset_rd_ready", bus.mem_read_ready, '0);
    check("reset_wr_ready", bus.mem_write_ready, '0);
    check("reset_rd_data", bus.mem_read_data, '0);
    repeat (2) @(negedge clk);
    check("reset_hold_ready", {bus.mem_read_ready, bus.mem_write_ready}, '0);
    check("reset3_rd_data", bus3.mem_read_data, '0);
    reset = 1'b1;

    for (int a = 0; a < (1 << AB); a++) load(AB'(a), DB'($urandom));

    // Load then read; ready latency, data and drop timing
    load(8'h10, 8'hA5);
    issue_round(4'b0001, '0, '0, pk(8'h10, 0, 0, 0), '0, '0, 1, 1'b0, '0, '0);
    check("req036_data_retained", bus.mem_read_data[0], 8'hA5);

    // Channel write followed by a read on another channel
    issue_round('0, 4'b0010, '0, '0, pk(0, 8'h20, 0, 0), pk(0, 8'h3C, 0, 0), 2, 1'b0, '0, '0);
    issue_round(4'b0100, '0, '0, pk(0, 0, 8'h20, 0), '0, '0, 0, 1'b0, '0, '0);
    check("req037_data", bus.mem_read_data[2], 8'h3C);

    // Same-edge writes to one address plus a backdoor load: channel 3 wins
    issue_round('0, 4'b1001, '0, '0, pk(8'h05, 0, 0, 8'h05), pk(8'h11, 0, 0, 8'h22), 0,
                1'b1, 8'h05, 8'h33);
    issue_round(4'b0001, '0, '0, pk(8'h05, 0, 0, 0), '0, '0, 0, 1'b0, '0, '0);
    check("req038_data", bus.mem_read_data[0], 8'h22);

    // Read and write committing on the same edge: read sees old value
    load(8'h40, 8'h01);
    issue_round(4'b0001, 4'b0010, '0, pk(8'h40, 0, 0, 0), pk(0, 8'h40, 0, 0), pk(0, 8'h02, 0, 0), 1,
                1'b0, '0, '0);
    check("req039_pre_write", bus.mem_read_data[0], 8'h01);
    issue_round(4'b1000, '0, '0, pk(0, 0, 0, 8'h40), '0, '0, 0, 1'b0, '0, '0);
    check("req039_post_write", bus.mem_read_data[3], 8'h02);

    // Aborted write leaves memory untouched
    issue_round('0, 4'b0100, 4'b0100, '0, pk(0, 0, 8'h05, 0), pk(0, 0, 8'h77, 0), 0, 1'b0, '0, '0);
    issue_round(4'b0010, '0, '0, pk(0, 8'h05, 0, 0), '0, '0, 0, 1'b0, '0, '0);
    check("req040_abort_data", bus.mem_read_data[1], 8'h22);

    // Reset pulsed while a read is busy; held valid restarts it afterwards
    @(negedge clk);
    bus.mem_read_valid[0] = 1'b1;
    bus.mem_read_address[0] = 8'h10;
    sb.push_back('{0, model[8'h10]});
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_ready", bus.mem_read_ready, '0);
    check("rst_mid_rdata", bus.mem_read_data, '0);
    #1 reset = 1'b1;
    k = 0;
    while (!bus.mem_read_ready[0] && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rst_restart_ready", bus.mem_read_ready[0], 1'b1);
    check("rst_restart_cycles", k, 2);
    bus.mem_read_valid = '0;
    @(negedge clk);
    check("rst_restart_drop", bus.mem_read_ready, '0);

    // LATENCY=3 instance: four simultaneous reads of distinct addresses
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      load_enable3 = 1'b1; load_address3 = AB'(8'h80 + c); load_data3 = DB'(8'hC0 + c);
    end
    @(negedge clk);
    load_enable3 = 1'b0;
    bus3.mem_read_valid = '1;
    bus3.mem_read_address = pk(8'h83, 8'h82, 8'h81, 8'h80);
    repeat (2) begin
      @(negedge clk);
      check("l3_busy", bus3.mem_read_ready, '0);
    end
    @(negedge clk);
    check("l3_ready", bus3.mem_read_ready, 4'hF);
    for (int c = 0; c < NC; c++)
      check($sformatf("l3_data_ch%0d", c), bus3.mem_read_data[c], DB'(8'hC3 - c));
    bus3.mem_read_valid = '0;
    @(negedge clk);
    check("l3_drop", bus3.mem_read_ready, '0);

    repeat (300) rand_round();

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
